key_repeat_conditioner: RTL and testbench
=========================================

// Module: key_repeat_conditioner
// PURPOSE
//  Front end for the push-button bank of the alarm clock.
//  - Synchronises and debounces the raw buttons, and accepts a press only when exactly one key is down.
//  - Drives the one-hot KEY bus that the clock/alarm control logic consumes, plus a one-cycle strobe per
//    accepted press and per auto-repeat.
//  - Replaces ad-hoc hold-to-repeat counting inside the time-keeping logic.
// PARAMETERS
//  N_KEYS        6          number of buttons (bit5 MIN+, bit4 SEC+, bit3 MIN-, bit2 SEC-, bit1 MODE, bit0 ALARM)
//  SYNC_STAGES   2          synchroniser flops on KEY_RAW (>=2)
//  DEBOUNCE_CYC  20         consecutive stable cycles to accept a press or a release (>=1)
//  REPEAT_DELAY  500        cycles from first strobe to first repeat strobe (>=1)
//  REPEAT_RATE   200        cycles between subsequent repeat strobes (>=1)
//  REPEAT_MASK   6'b111100  keys allowed to auto-repeat; MODE/ALARM toggles never repeat
// PORTS
//  clk        in   1       system clock (1 kHz in the clock design)
//  reset      in   1       asynchronous, active-high reset
//  KEY_RAW    in   N_KEYS  raw button levels, active-high, asynchronous to clk
//  KEY        out  N_KEYS  one-hot level of the accepted key, held while pressed; 0 otherwise
//  key_pulse  out  N_KEYS  one-cycle strobe (same code as KEY) on accept and on each repeat
//  chord      out  1       high while the synchronised input has >=2 bits set
// BEHAVIOUR
//  - Reset (async assert, sync release): synchronisers=0, state=IDLE, counters=0, KEY=0, key_pulse=0, chord=0.
//  - Outputs: all registered. s = synchroniser output. code = latched one-hot key.
//  - chord: registered from popcount(s)>=2 every cycle, in every state.
//  - FSM, one counter cnt (width clog2(max param)+1):
//   IDLE:    s one-hot -> code<=s, cnt<=1, DEB. s==0 or chord -> stay.
//   DEB:     s!=code -> IDLE (no output).
//            cnt==DEBOUNCE_CYC -> HELD, KEY<=code, key_pulse<=code (1 cycle), cnt<=1.
//            else cnt++.
//   HELD:    s!=code (release, chord or other key) -> REL.
//            code&REPEAT_MASK==0 -> stay, no strobes, cnt frozen.
//            else if cnt==REPEAT_DELAY -> key_pulse<=code, cnt<=1, RPT; else cnt++.
//   RPT:     s!=code -> REL. cnt==REPEAT_RATE -> key_pulse<=code, cnt<=1; else cnt++.
//   REL:     KEY<=0 on entry edge, no strobes. s==0 -> cnt++, else cnt<=0.
//            cnt==DEBOUNCE_CYC -> IDLE.
//  - Latency: edge E is the first to sample KEY_RAW stably one-hot. KEY and key_pulse assert at edge
//    E+SYNC_STAGES+DEBOUNCE_CYC.
//  - Repeat strobes: first at +REPEAT_DELAY after the first strobe, then every REPEAT_RATE cycles.
//  - Strobe count while held T cycles after acceptance: 1 + (T>=REPEAT_DELAY ? 1+floor((T-REPEAT_DELAY)/REPEAT_RATE) : 0).
//  - Glitch shorter than DEBOUNCE_CYC in DEB: no output, back to IDLE.
//  - Bounce during REL restarts the release count.
//  - Key switch without release (A held, B pressed, A dropped): goes through REL. B is only accepted
//    after all keys have been released for DEBOUNCE_CYC cycles.
//  - Simultaneous events:
//    - Chord from IDLE is never accepted.
//    - Chord during HELD/RPT is treated as release; KEY drops and the key is not resumed.
//  - Never more than one bit set in KEY or key_pulse.
//  - key_pulse never coincides with KEY==0.
//  - Reset mid-press: outputs clear immediately. After release, the still-held key needs a full
//    debounce from IDLE.
// TESTING (bench params DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3, SYNC_STAGES=2)
//  1. KEY_RAW=6'b100000 from edge 0, held 30 cycles.
//     -> KEY=6'b100000 from edge 6. Strobes at edges 6, 16, 19, 22, 25, 28 (6 total).
//  2. KEY_RAW=6'b010000 for 3 cycles, then 0.
//     -> KEY and key_pulse stay 0. FSM back in IDLE.
//  3. KEY_RAW=6'b000010 held 40 cycles (non-repeat key).
//     -> exactly one strobe 6'b000010. KEY held until release plus sync latency.
//  4. KEY_RAW=6'b101000 held.
//     -> chord=1 after 2 cycles. KEY=0 and no strobes.
//     Then drop to 6'b100000 -> accepted 6 edges later.
//  5. Press 6'b000100, accepted. Release with 1-cycle bounce (0,4'h0 x2, 6'b000100 x1, 0 x10).
//     -> KEY=0 at release detect. No extra strobe. IDLE reached 4 stable-zero cycles after the bounce.
//  6. Press 6'b100000, accepted at edge 6. Assert reset at edge 12 for 2 cycles, key still held.
//     -> all outputs 0 immediately. Re-accepted 6 edges after reset release with a fresh strobe.

Source files
------------

// File: rtl/key_repeat_conditioner.sv
// Push-button front end: synchronise, debounce, single-key accept,
// one-hot KEY level plus strobes on accept and on hold-to-repeat.
module key_repeat_conditioner #(
    parameter int N_KEYS       = 6,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 200,
    parameter logic [N_KEYS-1:0] REPEAT_MASK = 6'b111100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] KEY_RAW,
    output logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              chord
);

    localparam int MAX_AB = (DEBOUNCE_CYC > REPEAT_DELAY) ?
                            DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0]     C_ONE = CW'(1);
    localparam logic [CW-1:0]     C_DEB = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0]     C_RD  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0]     C_RR  = CW'(REPEAT_RATE);
    localparam logic [N_KEYS-1:0] K_ONE = N_KEYS'(1);

    typedef enum logic [2:0] {
        IDLE,
        DEB,
        HELD,
        RPT,
        REL
    } state_t;

    logic [SYNC_STAGES-1:0][N_KEYS-1:0] sync_q;
    logic [N_KEYS-1:0] s;
    logic              s_zero;
    logic              s_multi;
    logic              s_onehot;
    logic              s_match;
    logic              rep_ok;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_KEYS-1:0] code_q, code_d;
    logic [N_KEYS-1:0] key_d;
    logic [N_KEYS-1:0] pulse_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign s_zero   = (s == '0);
    assign s_multi  = ((s & (s - K_ONE)) != '0);
    assign s_onehot = !s_zero && !s_multi;
    assign s_match  = (s == code_q);
    assign rep_ok   = |(code_q & REPEAT_MASK);

    // Metastability synchroniser chain on the raw button levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], KEY_RAW};
        end
    end

    // State, counter, latched code and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            code_q    <= '0;
            KEY       <= '0;
            key_pulse <= '0;
            chord     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            KEY       <= key_d;
            key_pulse <= pulse_d;
            chord     <= s_multi;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (s_onehot) state_d = DEB;
            end
            DEB: begin
                if (!s_match)            state_d = IDLE;
                else if (cnt_q == C_DEB) state_d = HELD;
            end
            HELD: begin
                if (!s_match)                     state_d = REL;
                else if (rep_ok && cnt_q == C_RD) state_d = RPT;
            end
            RPT: begin
                if (!s_match) state_d = REL;
            end
            REL: begin
                if (s_zero && cnt_q == C_DEB) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, code latch and output values for the next edge
    always_comb begin
        cnt_d   = cnt_q;
        code_d  = code_q;
        key_d   = KEY;
        pulse_d = '0;
        unique case (state_q)
            IDLE: begin
                if (s_onehot) begin
                    code_d = s;
                    cnt_d  = C_ONE;
                end
            end
            DEB: begin
                if (!s_match) begin
                    cnt_d = '0;
                end else if (cnt_q == C_DEB) begin
                    key_d   = code_q;
                    pulse_d = code_q;
                    cnt_d   = C_ONE;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            HELD: begin
                if (!s_match) begin
                    key_d = '0;
                    cnt_d = s_zero ? C_ONE : '0;
                end else if (rep_ok) begin
                    if (cnt_q == C_RD) begin
                        pulse_d = code_q;
                        cnt_d   = C_ONE;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            RPT: begin
                if (!s_match) begin
                    key_d = '0;
                    cnt_d = s_zero ? C_ONE : '0;
                end else if (cnt_q == C_RR) begin
                    pulse_d = code_q;
                    cnt_d   = C_ONE;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            REL: begin
                key_d = '0;
                if (!s_zero)             cnt_d = '0;
                else if (cnt_q == C_DEB) cnt_d = '0;
                else                     cnt_d = cnt_q + C_ONE;
            end
            default: begin
                key_d = '0;
                cnt_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Bench for key_repeat_conditioner: strobes are predicted into a queue
// when a press is driven and matched when the DUT emits them.
module tb_key_repeat_conditioner;

    localparam int SS  = 2;
    localparam int DBC = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam logic [5:0] MASK = 6'b111100;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] KEY_RAW;
    logic [5:0] KEY;
    logic [5:0] key_pulse;
    logic       chord;

    typedef struct {
        int         edge_n;
        logic [5:0] code;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   base   = 0;

    key_repeat_conditioner #(
        .N_KEYS(6),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYC(DBC),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .KEY_RAW(KEY_RAW),
        .KEY(KEY),
        .key_pulse(key_pulse),
        .chord(chord)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: every strobe must be the next predicted one
    always @(negedge clk) begin
        if (!reset && key_pulse != 6'b0) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe edge %0d got %b want none",
                         cyc - base, key_pulse);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (cyc !== e.edge_n || key_pulse !== e.code) begin
                    errors++;
                    $display("FAIL strobe got edge %0d code %b want edge %0d code %b",
                             cyc - base, key_pulse, e.edge_n - base, e.code);
                end
            end
            checks++;
            if (KEY !== key_pulse) begin
                errors++;
                $display("FAIL strobe_vs_key got KEY %b want %b",
                         KEY, key_pulse);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic begin_test();
        @(negedge clk);
        base = cyc + 1;
    endtask

    // Park just after edge base+rel
    task automatic to(input int rel);
        while (cyc < base + rel) @(negedge clk);
    endtask

    // Predict strobes for a press sampled stably from edge p to edge l
    task automatic push(input int p, input int l, input logic [5:0] code);
        int a;
        int e;
        a = p + SS + DBC;
        if (l >= p + DBC) begin
            sbq.push_back('{base + a, code});
            if ((code & MASK) != 6'b0) begin
                e = a + RD;
                while (e - SS <= l) begin
                    sbq.push_back('{base + e, code});
                    e = e + RR;
                end
            end
        end
    endtask

    task automatic drained(input string name);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_strobes got %0d left want 0",
                     name, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        KEY_RAW = 6'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL rst_key got %b want 000000", KEY);
        end
        checks++;
        if (key_pulse !== 6'b0) begin
            errors++;
            $display("FAIL rst_pulse got %b want 000000", key_pulse);
        end
        checks++;
        if (chord !== 1'b0) begin
            errors++;
            $display("FAIL rst_chord got %b want 0", chord);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_repeat();
        begin_test();
        KEY_RAW = 6'b100000;
        push(0, 28, 6'b100000);
        to(5);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t1_key_e5 got %b want 000000", KEY);
        end
        to(6);
        checks++;
        if (KEY !== 6'b100000) begin
            errors++;
            $display("FAIL t1_key_e6 got %b want 100000", KEY);
        end
        to(28);
        KEY_RAW = 6'b0;
        to(30);
        checks++;
        if (KEY !== 6'b100000) begin
            errors++;
            $display("FAIL t1_key_e30 got %b want 100000", KEY);
        end
        to(31);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t1_key_e31 got %b want 000000", KEY);
        end
        to(46);
        drained("t1");
    endtask

    task automatic test_glitch();
        begin_test();
        KEY_RAW = 6'b010000;
        push(0, 2, 6'b010000);
        to(2);
        KEY_RAW = 6'b0;
        to(8);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t2_key got %b want 000000", KEY);
        end
        to(20);
        drained("t2");
    endtask

    task automatic test_no_repeat();
        begin_test();
        KEY_RAW = 6'b000010;
        push(0, 39, 6'b000010);
        to(5);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t3_key_e5 got %b want 000000", KEY);
        end
        to(6);
        checks++;
        if (KEY !== 6'b000010) begin
            errors++;
            $display("FAIL t3_key_e6 got %b want 000010", KEY);
        end
        to(39);
        KEY_RAW = 6'b0;
        to(41);
        checks++;
        if (KEY !== 6'b000010) begin
            errors++;
            $display("FAIL t3_key_e41 got %b want 000010", KEY);
        end
        to(42);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t3_key_e42 got %b want 000000", KEY);
        end
        to(57);
        drained("t3");
    endtask

    task automatic test_chord();
        begin_test();
        KEY_RAW = 6'b101000;
        to(1);
        checks++;
        if (chord !== 1'b0) begin
            errors++;
            $display("FAIL t4_chord_e1 got %b want 0", chord);
        end
        to(2);
        checks++;
        if (chord !== 1'b1) begin
            errors++;
            $display("FAIL t4_chord_e2 got %b want 1", chord);
        end
        to(9);
        KEY_RAW = 6'b100000;
        push(10, 17, 6'b100000);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t4_key_chord got %b want 000000", KEY);
        end
        to(12);
        checks++;
        if (chord !== 1'b0) begin
            errors++;
            $display("FAIL t4_chord_e12 got %b want 0", chord);
        end
        to(15);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t4_key_e15 got %b want 000000", KEY);
        end
        to(16);
        checks++;
        if (KEY !== 6'b100000) begin
            errors++;
            $display("FAIL t4_key_e16 got %b want 100000", KEY);
        end
        to(17);
        KEY_RAW = 6'b0;
        to(35);
        drained("t4");
    endtask

    task automatic test_key_switch();
        begin_test();
        KEY_RAW = 6'b001000;
        push(0, 7, 6'b001000);
        to(7);
        KEY_RAW = 6'b001100;
        to(9);
        checks++;
        if (KEY !== 6'b001000) begin
            errors++;
            $display("FAIL ts_key_e9 got %b want 001000", KEY);
        end
        to(10);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL ts_key_e10 got %b want 000000", KEY);
        end
        checks++;
        if (chord !== 1'b1) begin
            errors++;
            $display("FAIL ts_chord_e10 got %b want 1", chord);
        end
        to(14);
        KEY_RAW = 6'b000100;
        to(40);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL ts_key_e40 got %b want 000000", KEY);
        end
        KEY_RAW = 6'b0;
        to(58);
        drained("ts");
    endtask

    task automatic test_release_bounce();
        begin_test();
        KEY_RAW = 6'b000100;
        push(0, 9, 6'b000100);
        to(9);
        KEY_RAW = 6'b0;
        to(11);
        KEY_RAW = 6'b000100;
        checks++;
        if (KEY !== 6'b000100) begin
            errors++;
            $display("FAIL t5_key_e11 got %b want 000100", KEY);
        end
        to(12);
        KEY_RAW = 6'b0;
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t5_key_e12 got %b want 000000", KEY);
        end
        to(25);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t5_key_e25 got %b want 000000", KEY);
        end
        to(35);
        drained("t5");
    endtask

    task automatic test_reset_mid_press();
        begin_test();
        KEY_RAW = 6'b100000;
        // Reset after edge 12 cuts the press short; a fresh one
        // starts at edge 15, the first edge after release
        push(0, 11, 6'b100000);
        push(15, 24, 6'b100000);
        to(11);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (KEY !== 6'b0 || key_pulse !== 6'b0 || chord !== 1'b0) begin
            errors++;
            $display("FAIL t6_rst_clear got %b/%b/%b want 0/0/0",
                     KEY, key_pulse, chord);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        to(20);
        checks++;
        if (KEY !== 6'b0) begin
            errors++;
            $display("FAIL t6_key_e20 got %b want 000000", KEY);
        end
        to(21);
        checks++;
        if (KEY !== 6'b100000) begin
            errors++;
            $display("FAIL t6_key_e21 got %b want 100000", KEY);
        end
        to(24);
        KEY_RAW = 6'b0;
        to(42);
        drained("t6");
    endtask

    initial begin
        test_reset();
        test_repeat();
        test_glitch();
        test_no_repeat();
        test_chord();
        test_key_switch();
        test_release_bounce();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
